// File: rtl/mem_subword_seq.sv
// Load/store sequencer mapping byte/half/word CPU accesses onto a word-only MIO bus,
// with read-modify-write for sub-word stores, alignment checking and a per-phase bus timeout.
module mem_subword_seq #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_cause,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [2:0]        state_out
);
  localparam int BYTES      = DATA_W / 8;
  localparam int LB         = $clog2(BYTES);
  localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);
  localparam bit   TMO_EN     = (TIMEOUT > 0);

  localparam logic [1:0] CAUSE_OK    = 2'b00;
  localparam logic [1:0] CAUSE_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_TMO   = 2'b10;
  localparam logic [1:0] CAUSE_SIZE  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        rsp_cause_q, rsp_cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic [LB-1:0]     align_mask;
  logic [ADDR_W-1:0] word_addr;

  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] word,
    input logic [LB-1:0]     lane,
    input logic [1:0]        size,
    input logic              sgn
  );
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    int                nbits;
    sh    = word >> {lane, 3'b000};
    nbits = 8 << size;
    if (nbits > DATA_W) nbits = DATA_W;
    res   = sh;
    for (int b = 0; b < DATA_W; b++) begin
      if (b >= nbits) res[b] = sgn & sh[nbits-1];
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] wdata,
    input logic [LB-1:0]     lane,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] ins;
    logic [DATA_W-1:0] res;
    int                lo;
    int                hi;
    ins = wdata << {lane, 3'b000};
    lo  = int'(lane);
    hi  = lo + (1 << size);
    res = word;
    for (int i = 0; i < BYTES; i++) begin
      if (i >= lo && i < hi) res[8*i +: 8] = ins[8*i +: 8];
    end
    return res;
  endfunction

  assign align_mask = ~({LB{1'b1}} << req_size);
  assign word_addr  = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_cause_d = rsp_cause_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    word_d      = word_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_addr[LB-1:0];
          wdata_d = req_wdata;
          if (int'(req_size) > LB) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_cause_d = CAUSE_SIZE;
          end else if ((req_addr[LB-1:0] & align_mask) != '0) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_cause_d = CAUSE_MISAL;
          end else if (req_we && int'(req_size) == LB) begin
            state_d     = WR;
            mem_addr_d  = word_addr;
            mem_wdata_d = req_wdata;
            cnt_d       = '0;
          end else begin
            // Loads and sub-word stores both start with a full-word read.
            state_d    = RD;
            mem_addr_d = word_addr;
            cnt_d      = '0;
          end
        end
      end
      RD: begin
        if (mem_ready) begin
          word_d = mem_rdata;
          if (we_q) begin
            state_d = MERGE;
          end else begin
            state_d     = RESP;
            rsp_rdata_d = load_extract(mem_rdata, lane_q, size_q, sgn_q);
            rsp_err_d   = 1'b0;
            rsp_cause_d = CAUSE_OK;
          end
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_cause_d = CAUSE_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MERGE: begin
        state_d     = WR;
        mem_wdata_d = store_merge(word_q, wdata_q, lane_q, size_q);
        cnt_d       = '0;
      end
      WR: begin
        if (mem_ready) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_cause_d = CAUSE_OK;
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_cause_d = CAUSE_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and bus-visible registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_cause_q <= CAUSE_OK;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_cause_q <= rsp_cause_d;
      cnt_q       <= cnt_d;
    end
  end

  // Captured request and read word
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    lane_q  <= lane_d;
    wdata_q <= wdata_d;
    word_q  <= word_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_rd    = (state_q == RD);
  assign mem_wr    = (state_q == WR);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_cause = rsp_cause_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mem_subword_seq.sv
// Randomized bench for mem_subword_seq: a word-memory responder plus a byte-level
// reference model predicting response fields, latency, bus strobes and memory contents.
module tb_mem_subword_seq;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  mem_subword_seq #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_cause(rsp_cause),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .state_out(state_out)
  );

  logic [31:0] mem [logic [31:0]];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h5A5A_0000 ^ (a * 32'h0100_0193);
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input bit stuck, input bit poke);
    logic [31:0] waddr, old_w, exp_w, exp_mem, exp_rd, shifted, mask;
    logic [1:0]  exp_cause;
    int          lane, nb, exp_lat, exp_rdc, exp_wrc, rdc, wrc, phase, edges;
    bit          seen, prev_st;

    waddr     = addr & ~32'h3;
    lane      = int'(addr % 4);
    old_w     = rdw(waddr);
    exp_w     = old_w;
    exp_mem   = old_w;
    exp_rd    = '0;
    exp_rdc   = 0;
    exp_wrc   = 0;
    exp_lat   = 1;
    exp_cause = 2'd0;
    nb        = 1 << size;
    if (size == 2'd3) begin
      exp_cause = 2'd3;
    end else if (addr % nb != 0) begin
      exp_cause = 2'd1;
    end else if (!we) begin
      shifted = old_w >> (8 * lane);
      mask    = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
      exp_rd  = shifted & mask;
      if (sgn && shifted[8*nb-1]) exp_rd = exp_rd | ~mask;
      if (stuck) begin
        exp_cause = 2'd2; exp_rd = '0; exp_rdc = TMO; exp_lat = 1 + TMO;
      end else begin
        exp_rdc = waits + 1; exp_lat = waits + 2;
      end
    end else begin
      for (int i = 0; i < nb; i++) exp_w[8*(lane+i) +: 8] = wdata[8*i +: 8];
      if (nb == 4) begin
        exp_wrc = stuck ? TMO : waits + 1;
        exp_lat = 1 + exp_wrc;
      end else if (stuck) begin
        exp_rdc = TMO; exp_lat = 1 + TMO;
      end else begin
        exp_rdc = waits + 1; exp_wrc = waits + 1; exp_lat = 2 * waits + 4;
      end
      if (stuck) exp_cause = 2'd2;
      else exp_mem = exp_w;
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    edges = 1; seen = 1'b0; prev_st = 1'b0; rdc = 0; wrc = 0; phase = 0;

    for (int c = 0; c < 64 && !seen; c++) begin
      req_valid = 1'b0;
      if (rsp_valid) begin
        seen = 1'b1;
        mem_ready = 1'($urandom);
      end else begin
        chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
        if (mem_rd || mem_wr) begin
          bit rdy;
          if (!prev_st) phase = 0;
          chk("mem_addr", mem_addr, waddr);
          if (mem_wr) chk("mem_wdata", mem_wdata, exp_w);
          rdy       = !stuck && (phase == waits);
          mem_ready = rdy;
          mem_rdata = rdw(mem_addr);
          if (mem_rd) rdc++;
          else wrc++;
          if (mem_wr && rdy) mem[mem_addr] = mem_wdata;
          if (poke && mem_rd && rdc == 1) begin
            chk("busy_ready", 32'(req_ready), 32'd0);
            req_valid = 1'b1; req_we = ~we; req_addr = 32'h44; req_size = 2'd0;
          end
          phase++;
        end else begin
          mem_ready = 1'($urandom);
          mem_rdata = $urandom;
        end
        prev_st = mem_rd || mem_wr;
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end

    chk("rsp_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(edges), 32'(exp_lat));
      chk("rsp_err", 32'(rsp_err), 32'(exp_cause != 2'd0));
      chk("rsp_cause", 32'(rsp_cause), 32'(exp_cause));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("state_resp", 32'(state_out), 32'd4);
      chk("rd_cycles", 32'(rdc), 32'(exp_rdc));
      chk("wr_cycles", 32'(wrc), 32'(exp_wrc));
      chk("mem_word", rdw(waddr), exp_mem);
      @(posedge clk);
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("rsp_hold", rsp_rdata, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old3004;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_cause", 32'(rsp_cause), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    mem[32'h1000] = 32'h80FF_1234;
    mem[32'h2000] = 32'h1122_3344;
    mem[32'h0010] = 32'hABCD_9876;

    run_req(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0, 1'b0, 1'b0);
    chk("lb_signed", rsp_rdata, 32'hFFFF_FF80);
    run_req(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 0, 1'b0, 1'b0);
    chk("lbu", rsp_rdata, 32'h0000_0080);
    run_req(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 0, 1'b0, 1'b0);
    chk("sh_merge", rdw(32'h2000), 32'hBEEF_3344);
    run_req(1'b1, 2'd2, 1'b0, 32'h2001, 32'h1234_5678, 0, 1'b0, 1'b0);
    run_req(1'b0, 2'd3, 1'b0, 32'h2000, 32'h0, 0, 1'b0, 1'b0);
    run_req(1'b0, 2'd1, 1'b0, 32'h0010, 32'h0, 3, 1'b0, 1'b1);
    chk("lhu_delay", rsp_rdata, 32'h0000_9876);
    run_req(1'b0, 2'd2, 1'b0, 32'h0020, 32'h0, 0, 1'b1, 1'b0);
    run_req(1'b1, 2'd0, 1'b0, 32'h0021, 32'h0000_005A, 1, 1'b1, 1'b0);
    run_req(1'b1, 2'd2, 1'b0, 32'h0024, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);
    run_req(1'b1, 2'd0, 1'b1, 32'h0033, 32'hFFFF_FFA7, 2, 1'b0, 1'b0);
    run_req(1'b0, 2'd1, 1'b1, 32'h0032, 32'h0, 0, 1'b0, 1'b0);

    // Reset in the middle of a write phase
    old3004 = rdw(32'h3004);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h3004; req_wdata = 32'hCAFE_F00D; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_before_rst", 32'(mem_wr), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mid_state", 32'(state_out), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1 chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_wr", 32'(mem_wr), 32'd0);
    end
    chk("rst_no_write", rdw(32'h3004), old3004);
    run_req(1'b1, 2'd2, 1'b0, 32'h3000, 32'h0BAD_BEEF, 1, 1'b0, 1'b0);
    chk("sw_after_rst", rdw(32'h3000), 32'h0BAD_BEEF);

    for (int k = 0; k < 80; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 2)),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
